// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded controls, operands and register
// specifiers for the EX stage, with stall (hold) and bubble (flush) handling.
module id_ex_reg #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic [1:0]        jump,
    input  logic              branch,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              alu_src,
    input  logic              reg_write,
    input  logic [1:0]        mem_to_reg,
    input  logic [1:0]        reg_dst,
    input  logic [3:0]        alu_op,
    input  logic [WORD_W-1:0] pc_value,
    input  logic [WORD_W-1:0] reg_data_1,
    input  logic [WORD_W-1:0] reg_data_2,
    input  logic [WORD_W-1:0] imm,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    output logic [1:0]        jump_out,
    output logic              branch_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              alu_src_out,
    output logic              reg_write_out,
    output logic [1:0]        mem_to_reg_out,
    output logic [1:0]        reg_dst_out,
    output logic [3:0]        alu_op_out,
    output logic [WORD_W-1:0] pc_value_out,
    output logic [WORD_W-1:0] reg_data_1_out,
    output logic [WORD_W-1:0] reg_data_2_out,
    output logic [WORD_W-1:0] imm_out,
    output logic [4:0]        rs_out,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out,
    output logic              valid_out
);

    logic [1:0]        jump_p1;
    logic              branch_p1;
    logic              mem_read_p1;
    logic              mem_write_p1;
    logic              alu_src_p1;
    logic              reg_write_p1;
    logic [1:0]        mem_to_reg_p1;
    logic [1:0]        reg_dst_p1;
    logic [3:0]        alu_op_p1;
    logic [WORD_W-1:0] pc_value_p1;
    logic [WORD_W-1:0] reg_data_1_p1;
    logic [WORD_W-1:0] reg_data_2_p1;
    logic [WORD_W-1:0] imm_p1;
    logic [4:0]        rs_p1;
    logic [4:0]        rt_p1;
    logic [4:0]        rd_p1;
    logic              vld_p1;

    // The upstream bubble mux zeroes every control field, so an all-zero
    // control word marks a bubble rather than a real instruction.
    function automatic logic ctrl_live(
        input logic [1:0] j, input logic br, input logic mr, input logic mw,
        input logic as, input logic rw, input logic [1:0] m2r,
        input logic [1:0] rdst, input logic [3:0] op
    );
        return |{j, br, mr, mw, as, rw, m2r, rdst, op};
    endfunction

    // ID -> EX stage boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            jump_p1       <= '0;
            branch_p1     <= 1'b0;
            mem_read_p1   <= 1'b0;
            mem_write_p1  <= 1'b0;
            alu_src_p1    <= 1'b0;
            reg_write_p1  <= 1'b0;
            mem_to_reg_p1 <= '0;
            reg_dst_p1    <= '0;
            alu_op_p1     <= '0;
            pc_value_p1   <= '0;
            reg_data_1_p1 <= '0;
            reg_data_2_p1 <= '0;
            imm_p1        <= '0;
            rs_p1         <= '0;
            rt_p1         <= '0;
            rd_p1         <= '0;
            vld_p1        <= 1'b0;
        end else if (!hold) begin
            jump_p1       <= jump;
            branch_p1     <= branch;
            mem_read_p1   <= mem_read;
            mem_write_p1  <= mem_write;
            alu_src_p1    <= alu_src;
            reg_write_p1  <= reg_write;
            mem_to_reg_p1 <= mem_to_reg;
            reg_dst_p1    <= reg_dst;
            alu_op_p1     <= alu_op;
            pc_value_p1   <= pc_value;
            reg_data_1_p1 <= reg_data_1;
            reg_data_2_p1 <= reg_data_2;
            imm_p1        <= imm;
            rs_p1         <= rs;
            rt_p1         <= rt;
            rd_p1         <= rd;
            vld_p1        <= ctrl_live(jump, branch, mem_read, mem_write, alu_src,
                                       reg_write, mem_to_reg, reg_dst, alu_op);
        end
    end

    assign jump_out       = jump_p1;
    assign branch_out     = branch_p1;
    assign mem_read_out   = mem_read_p1;
    assign mem_write_out  = mem_write_p1;
    assign alu_src_out    = alu_src_p1;
    assign reg_write_out  = reg_write_p1;
    assign mem_to_reg_out = mem_to_reg_p1;
    assign reg_dst_out    = reg_dst_p1;
    assign alu_op_out     = alu_op_p1;
    assign pc_value_out   = pc_value_p1;
    assign reg_data_1_out = reg_data_1_p1;
    assign reg_data_2_out = reg_data_2_p1;
    assign imm_out        = imm_p1;
    assign rs_out         = rs_p1;
    assign rt_out         = rt_p1;
    assign rd_out         = rd_p1;
    assign valid_out      = vld_p1;

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter: WORD_W, 32, width of datapath words (PC, register operands, immediate).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 hold  input  1  freeze register contents (EX stage stalled downstream).
REQ-005 flush  input  1  replace next captured contents with a bubble (taken branch/jump).
REQ-006 jump  input  2  control, from ID-stage bubble mux.
REQ-007 branch, mem_read, mem_write, alu_src, reg_write  input  1 each  control, from ID-stage bubble mux.
REQ-008 mem_to_reg, reg_dst  input  2 each  control, from ID-stage bubble mux.
REQ-009 alu_op  input  4  ALU operation select, from ID-stage bubble mux.
REQ-010 pc_value, reg_data_1, reg_data_2, imm  input  WORD_W each  PC+4, rs data, rt data, sign-extended immediate.
REQ-011 rs, rt, rd  input  5 each  register specifiers, used by forwarding unit.
REQ-012 <name>_out  output  same width as <name>  registered copy of each input in REQ-006..REQ-011.
REQ-013 valid_out  output  1  1 = EX stage holds a real instruction; 0 = bubble.

Function
REQ-014 All outputs SHALL be driven directly from flops; no combinational path from any input to any output.
REQ-015 Latency SHALL be exactly one clk cycle from input to corresponding _out when hold=0 and flush=0.
REQ-016 Per-edge priority SHALL be rst > flush > hold > load.
REQ-017 Load (hold=0, flush=0): every _out SHALL take its input value; valid_out SHALL become 1 unless the captured controls are all zero (bubble from upstream mux), in which case valid_out SHALL become 0.
REQ-018 Hold (hold=1, flush=0): every output including valid_out SHALL keep its current value, regardless of input changes.
REQ-019 Flush (flush=1): all control outputs (jump..alu_op) SHALL become 0, valid_out SHALL become 0; data and specifier outputs SHALL become 0.
REQ-020 Simultaneous flush=1 and hold=1: flush SHALL win; bubble inserted.
REQ-021 Bubble outputs SHALL guarantee reg_write_out=0 and mem_write_out=0 so no architectural state changes downstream.
REQ-022 Block SHALL perform no arithmetic; widths pass through unchanged, no sign/zero extension.
REQ-023 Two-state outputs only; no X propagation from unused inputs after reset.

Reset
REQ-024 rst=1 SHALL immediately (without clk) force every output to 0, including valid_out.
REQ-025 While rst=1, clk edges SHALL have no effect; outputs remain 0.
REQ-026 Reset asserted mid-hold SHALL discard held contents; first edge after rst deasserts SHALL perform a normal load/hold/flush per REQ-016.
REQ-027 Reset deassertion SHALL be treated as synchronous to clk by the surrounding system; no internal synchronizer is required.

Verification
REQ-028 Load: rst released, hold=0, flush=0, reg_write=1, alu_op=4'h2, rs=5'd8, imm=32'hFFFF_FFFC -> after one edge reg_write_out=1, alu_op_out=4'h2, rs_out=5'd8, imm_out=32'hFFFF_FFFC, valid_out=1.
REQ-029 Hold: loaded as REQ-028, then hold=1 for 3 edges with all inputs changed to new values -> outputs unchanged for all 3 cycles; hold=0 -> new values appear after next edge.
REQ-030 Flush: loaded state, flush=1 with mem_write=1, reg_write=1 on inputs -> after edge all control and data outputs 0, valid_out=0; flush=1 with hold=1 gives same result.
REQ-031 Upstream bubble: all control inputs 0, pc_value=32'h0000_0040 -> pc_value_out=32'h0000_0040, valid_out=0.
REQ-032 Async reset: rst pulsed high between clk edges while loaded -> all outputs 0 before next edge; remain 0 across edges while rst=1.
REQ-033 Back-to-back stream: 8 consecutive distinct instructions, no hold/flush -> each appears on outputs exactly one cycle after presentation, in order, none dropped or duplicated.
